// File: rtl/if_id_buffer.sv
// IF/ID pipeline register: captures the fetched word, immediate and next PC,
// with stall hold, flush bubbles and an interrupt-entry bubble drain.
module if_id_buffer #(
  parameter int unsigned      INST_W      = 16,
  parameter int unsigned      PC_W        = 32,
  parameter logic [INST_W-1:0] NOP_WORD   = 16'h0000,
  parameter int unsigned      INT_BUBBLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              interruptBit,
  input  logic [INST_W-1:0] instrIn,
  input  logic [INST_W-1:0] immIn,
  input  logic [PC_W-1:0]   pcIn,
  input  logic [PC_W-1:0]   samePcIn,
  output logic [INST_W-1:0] instrOut,
  output logic [INST_W-1:0] immOut,
  output logic [PC_W-1:0]   pcOut,
  output logic              validOut,
  output logic [PC_W-1:0]   savedPc,
  output logic              intActive
);

  localparam int unsigned CNT_W = 3;

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [INST_W-1:0] instr_d, imm_d;
  logic [PC_W-1:0]   pc_d, saved_d;
  logic              valid_d, int_d;

  // Next-state and next-output selection; everything holds unless told otherwise
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    instr_d = instrOut;
    imm_d   = immOut;
    pc_d    = pcOut;
    valid_d = validOut;
    saved_d = savedPc;
    int_d   = intActive;
    case (state_q)
      RUN: begin
        if (flush) begin
          instr_d = NOP_WORD;
          imm_d   = '0;
          valid_d = 1'b0;
          pc_d    = pcIn;
        end else if (interruptBit) begin
          // Return to the interrupted word so it is re-fetched afterwards
          saved_d = samePcIn;
          instr_d = NOP_WORD;
          imm_d   = '0;
          valid_d = 1'b0;
          cnt_d   = CNT_W'(INT_BUBBLES - 1);
          int_d   = 1'b1;
          state_d = DRAIN;
        end else if (!stall) begin
          instr_d = instrIn;
          imm_d   = immIn;
          pc_d    = pcIn;
          valid_d = 1'b1;
        end
      end
      DRAIN: begin
        if (!stall && cnt_q == '0) begin
          // Drain complete: this edge already behaves as a normal RUN edge
          state_d = RUN;
          int_d   = 1'b0;
          if (flush) begin
            instr_d = NOP_WORD;
            imm_d   = '0;
            valid_d = 1'b0;
            pc_d    = pcIn;
          end else begin
            instr_d = instrIn;
            imm_d   = immIn;
            pc_d    = pcIn;
            valid_d = 1'b1;
          end
        end else begin
          instr_d = NOP_WORD;
          imm_d   = '0;
          valid_d = 1'b0;
          if (flush) pc_d = pcIn;
          if (!stall) cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = RUN;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      instrOut  <= NOP_WORD;
      immOut    <= '0;
      pcOut     <= '0;
      validOut  <= 1'b0;
      savedPc   <= '0;
      intActive <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      instrOut  <= instr_d;
      immOut    <= imm_d;
      pcOut     <= pc_d;
      validOut  <= valid_d;
      savedPc   <= saved_d;
      intActive <= int_d;
    end
  end

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed self-checking bench for if_id_buffer.
module tb_if_id_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush, interruptBit;
  logic [15:0] instrIn, immIn, instrOut, immOut;
  logic [31:0] pcIn, samePcIn, pcOut, savedPc;
  logic        validOut, intActive;

  int errors = 0;
  int checks = 0;

  if_id_buffer dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .interruptBit(interruptBit), .instrIn(instrIn), .immIn(immIn),
    .pcIn(pcIn), .samePcIn(samePcIn), .instrOut(instrOut), .immOut(immOut),
    .pcOut(pcOut), .validOut(validOut), .savedPc(savedPc), .intActive(intActive)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; stall = 0; flush = 0; interruptBit = 0;
    instrIn = '0; immIn = '0; pcIn = '0; samePcIn = '0;
    step(); step();
    chk("rst_instr", 32'(instrOut), 32'h0);
    chk("rst_valid", 32'(validOut), 32'h0);
    chk("rst_int", 32'(intActive), 32'h0);
    chk("rst_saved", savedPc, 32'h0);
    rst = 1'b1;

    // Load, then asynchronous reset mid-run
    instrIn = 16'h1234; immIn = 16'h0077; pcIn = 32'd5;
    step();
    chk("load_instr", 32'(instrOut), 32'h1234);
    chk("load_imm", 32'(immOut), 32'h0077);
    chk("load_pc", pcOut, 32'd5);
    chk("load_valid", 32'(validOut), 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("async_instr", 32'(instrOut), 32'h0);
    chk("async_imm", 32'(immOut), 32'h0);
    chk("async_pc", pcOut, 32'h0);
    chk("async_valid", 32'(validOut), 32'h0);
    rst = 1'b1;
    step();
    chk("reload_instr", 32'(instrOut), 32'h1234);
    chk("reload_pc", pcOut, 32'd5);
    chk("reload_valid", 32'(validOut), 32'h1);

    // Stall holds for three cycles
    instrIn = 16'hA001; pcIn = 32'd6;
    step();
    chk("stall_pre", 32'(instrOut), 32'hA001);
    stall = 1; instrIn = 16'hB002; pcIn = 32'd7;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_hold", 32'(instrOut), 32'hA001);
      chk("stall_valid", 32'(validOut), 32'h1);
    end
    stall = 0;
    step();
    chk("stall_release", 32'(instrOut), 32'hB002);

    // Flush overrides stall
    stall = 1; flush = 1; pcIn = 32'h40;
    step();
    chk("flush_instr", 32'(instrOut), 32'h0);
    chk("flush_valid", 32'(validOut), 32'h0);
    chk("flush_pc", pcOut, 32'h40);
    stall = 0; flush = 0;

    // Interrupt entry with two bubbles
    instrIn = 16'hC003; pcIn = 32'd8;
    step();
    chk("pre_int_valid", 32'(validOut), 32'h1);
    samePcIn = 32'h10; interruptBit = 1;
    step();
    chk("int_saved", savedPc, 32'h10);
    chk("int_active", 32'(intActive), 32'h1);
    chk("int_bub1", 32'(validOut), 32'h0);
    chk("int_bub1_instr", 32'(instrOut), 32'h0);
    interruptBit = 0; instrIn = 16'hD004; pcIn = 32'd9;
    step();
    chk("int_bub2", 32'(validOut), 32'h0);
    chk("int_bub2_active", 32'(intActive), 32'h1);
    step();
    chk("int_done_active", 32'(intActive), 32'h0);
    chk("int_resume_instr", 32'(instrOut), 32'hD004);
    chk("int_resume_valid", 32'(validOut), 32'h1);

    // Interrupt entry with stall during drain: four bubbles
    samePcIn = 32'h20; interruptBit = 1;
    step();
    chk("ints_saved", savedPc, 32'h20);
    chk("ints_active", 32'(intActive), 32'h1);
    interruptBit = 0; stall = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("ints_stall_valid", 32'(validOut), 32'h0);
      chk("ints_stall_active", 32'(intActive), 32'h1);
    end
    stall = 0; instrIn = 16'hE005;
    step();
    chk("ints_bub4_valid", 32'(validOut), 32'h0);
    chk("ints_bub4_active", 32'(intActive), 32'h1);
    step();
    chk("ints_done_active", 32'(intActive), 32'h0);
    chk("ints_resume_instr", 32'(instrOut), 32'hE005);

    // Flush together with interrupt: flush wins, held request enters next edge
    instrIn = 16'hF006;
    step();
    chk("fi_pre_valid", 32'(validOut), 32'h1);
    flush = 1; interruptBit = 1; samePcIn = 32'h30; pcIn = 32'h44;
    step();
    chk("fi_valid", 32'(validOut), 32'h0);
    chk("fi_active", 32'(intActive), 32'h0);
    chk("fi_saved", savedPc, 32'h20);
    chk("fi_pc", pcOut, 32'h44);
    flush = 0;
    step();
    chk("fi_entry_active", 32'(intActive), 32'h1);
    chk("fi_entry_saved", savedPc, 32'h30);
    interruptBit = 0;
    step();
    chk("fi_bub2_active", 32'(intActive), 32'h1);
    step();
    chk("fi_done_active", 32'(intActive), 32'h0);
    chk("fi_resume_instr", 32'(instrOut), 32'hF006);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
